// File: rtl/intmul_folded.sv
// intmul_folded: folded unsigned multiply-accumulate, out_c = a*b + c.
// Tile products are issued N_MUL per cycle and summed into one accumulator.
module intmul_folded #(
  parameter  int W_A    = 60,
  parameter  int W_B    = 60,
  parameter  int TILE_A = 26,
  parameter  int TILE_B = 17,
  parameter  int N_MUL  = 4,
  parameter  int FF_MUL = 1,
  parameter  int ID_W   = 4,
  localparam int W_C    = W_A + W_B
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W_A-1:0]  in_a,
  input  logic [W_B-1:0]  in_b,
  input  logic [W_C-1:0]  in_c,
  input  logic [ID_W-1:0] in_tag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W_C-1:0]  out_c,
  output logic [ID_W-1:0] out_tag
);

  localparam int NA   = (W_A + TILE_A - 1) / TILE_A;
  localparam int NB   = (W_B + TILE_B - 1) / TILE_B;
  localparam int NT   = NA * NB;
  localparam int NCYC = (NT + N_MUL - 1) / N_MUL;
  localparam int AP   = NA * TILE_A;
  localparam int BP   = NB * TILE_B;
  localparam int WX   = W_C + TILE_A + TILE_B;
  localparam int CW   = $clog2(NCYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  logic [AP-1:0]   r_a;
  logic [BP-1:0]   r_b;
  logic [ID_W-1:0] r_tag;
  logic [W_C-1:0]  r_acc;
  logic [CW-1:0]   r_cnt;
  logic [W_C-1:0]  r_prod;
  logic            r_pv;
  logic            r_pl;
  logic            r_ov;

  logic [W_C-1:0]  w_grp;
  logic            w_in_xfer;
  logic            w_out_xfer;
  logic            w_last;

  assign in_ready   = !rst &&
                      (r_state == S_IDLE ||
                       (r_state == S_DONE && out_ready));
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_ov && out_ready;
  assign w_last     = (r_cnt == CW'(NCYC - 1));

  assign out_valid  = r_ov;
  assign out_c      = r_acc;
  assign out_tag    = r_tag;

  // Shifted sum of the tile products belonging to group r_cnt.
  always_comb begin
    int t;
    int ti;
    int tj;
    logic [TILE_A-1:0] ta;
    logic [TILE_B-1:0] tb;
    logic [WX-1:0] p;
    t     = 0;
    ti    = 0;
    tj    = 0;
    ta    = '0;
    tb    = '0;
    p     = '0;
    w_grp = '0;
    for (int m = 0; m < N_MUL; m++) begin
      t = int'(r_cnt) * N_MUL + m;
      if (t < NT) begin
        ti    = t % NA;
        tj    = t / NA;
        ta    = TILE_A'(r_a >> (ti * TILE_A));
        tb    = TILE_B'(r_b >> (tj * TILE_B));
        p     = WX'(ta) * WX'(tb);
        w_grp = w_grp +
                W_C'(p << (ti * TILE_A + tj * TILE_B));
      end
    end
  end

  // Control FSM, operand latch, product pipe and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_prod  <= '0;
      r_pv    <= 1'b0;
      r_pl    <= 1'b0;
      r_ov    <= 1'b0;
    end else if (w_in_xfer) begin
      r_state <= S_RUN;
      r_a     <= AP'(in_a);
      r_b     <= BP'(in_b);
      r_tag   <= in_tag;
      r_acc   <= in_c;
      r_cnt   <= '0;
      r_pv    <= 1'b0;
      r_pl    <= 1'b0;
      r_ov    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_ov <= 1'b0;
        end
        S_RUN: begin
          if (FF_MUL != 0) begin
            if (r_cnt != CW'(NCYC)) begin
              r_prod <= w_grp;
              r_pv   <= 1'b1;
              r_pl   <= w_last;
              r_cnt  <= r_cnt + 1'b1;
            end else begin
              r_pv <= 1'b0;
              r_pl <= 1'b0;
            end
            if (r_pv) begin
              r_acc <= r_acc + r_prod;
              if (r_pl) begin
                r_state <= S_DONE;
                r_ov    <= 1'b1;
              end
            end
          end else begin
            r_acc <= r_acc + w_grp;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
              r_ov    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          if (w_out_xfer) begin
            r_state <= S_IDLE;
            r_ov    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_ov    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intmul_folded.sv
// tb_intmul_folded: scoreboard bench for the folded multiply-accumulate.
// Expected results come from plain wide arithmetic, not from the tiling.
module tb_intmul_folded;

  parameter int N_MUL  = 4;
  parameter int FF_MUL = 1;

  localparam int W_A    = 60;
  localparam int W_B    = 60;
  localparam int TILE_A = 26;
  localparam int TILE_B = 17;
  localparam int ID_W   = 4;
  localparam int W_C    = W_A + W_B;
  localparam int NA     = (W_A + TILE_A - 1) / TILE_A;
  localparam int NB     = (W_B + TILE_B - 1) / TILE_B;
  localparam int NT     = NA * NB;
  localparam int NCYC   = (NT + N_MUL - 1) / N_MUL;
  localparam int L      = NCYC + FF_MUL;
  localparam int NREQ   = 2500;

  typedef struct {
    logic [W_C-1:0]  c;
    logic [ID_W-1:0] tag;
    int              cyc;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W_A-1:0]  in_a;
  logic [W_B-1:0]  in_b;
  logic [W_C-1:0]  in_c;
  logic [ID_W-1:0] in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [W_C-1:0]  out_c;
  logic [ID_W-1:0] out_tag;

  exp_t q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   rnd_ord = 1'b0;
  bit   prev_ov = 1'b0;

  intmul_folded #(
    .W_A(W_A), .W_B(W_B),
    .TILE_A(TILE_A), .TILE_B(TILE_B),
    .N_MUL(N_MUL), .FF_MUL(FF_MUL),
    .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .in_c(in_c), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_c(out_c), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W_C-1:0] model(
    input logic [W_A-1:0] a,
    input logic [W_B-1:0] b,
    input logic [W_C-1:0] c
  );
    logic [2*W_C-1:0] f;
    f = (2*W_C)'(a) * (2*W_C)'(b) + (2*W_C)'(c);
    return W_C'(f);
  endfunction

  function automatic logic [W_A-1:0] rnd_op(input int sel);
    logic [63:0] r;
    r = {$urandom, $urandom};
    if (sel == 0) return '1;
    if (sel == 1) return '0;
    return W_A'(r);
  endfunction

  task automatic chk(
    input string name,
    input logic [W_C-1:0] act,
    input logic [W_C-1:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  task automatic push_exp();
    exp_t e;
    e.c   = model(in_a, in_b, in_c);
    e.tag = in_tag;
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  // Called at a falling edge; holds the request until accepted.
  task automatic send(
    input logic [W_A-1:0] a,
    input logic [W_B-1:0] b,
    input logic [W_C-1:0] c,
    input logic [ID_W-1:0] tag
  );
    bit done;
    done     = 1'b0;
    in_a     = a;
    in_b     = b;
    in_c     = c;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      #1;
      if (in_ready) begin
        push_exp();
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) fail_now("send_timeout");
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) fail_now("drain_timeout");
  endtask

  // Random consumer back-pressure during the random phase.
  initial forever begin
    @(negedge clk);
    if (rnd_ord) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency on each rise of out_valid, data on each transfer.
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (q.size() == 0) fail_now("spurious_valid");
        else chk("latency", W_C'(cyc - q[0].cyc), W_C'(L));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          fail_now("extra_result");
        end else begin
          chk("out_c", out_c, q[0].c);
          chk("out_tag", W_C'(out_tag), W_C'(q[0].tag));
          void'(q.pop_front());
        end
      end
      prev_ov = out_valid && !out_ready;
    end
  end

  initial begin
    exp_t e;
    int   n;
    int   guard;
    int   k;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_c      = '0;
    in_tag    = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", W_C'(in_ready), '0);
    chk("rst_out_valid", W_C'(out_valid), '0);
    chk("rst_out_c", out_c, '0);
    chk("rst_out_tag", W_C'(out_tag), '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", W_C'(in_ready), W_C'(1));
    out_ready = 1'b1;
    @(negedge clk);

    send(60'd3, 60'd5, 120'd7, 4'hA);
    wait_drain();
    send('1, '1, '0, 4'h1);
    send('1, '1, (W_C)'({61{1'b1}}), 4'h2);
    wait_drain();

    // Held result under back-pressure, then overlapping transfers.
    @(negedge clk);
    out_ready = 1'b0;
    send(rnd_op(2), rnd_op(2), {rnd_op(2), rnd_op(2)}, 4'h5);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!out_valid) fail_now("valid_timeout");
    e = q[0];
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("hold_c", out_c, e.c);
      chk("hold_tag", W_C'(out_tag), W_C'(e.tag));
      chk("hold_valid", W_C'(out_valid), W_C'(1));
      chk("hold_ready", W_C'(in_ready), '0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_a      = rnd_op(2);
    in_b      = rnd_op(2);
    in_c      = {rnd_op(2), rnd_op(2)};
    in_tag    = 4'h6;
    in_valid  = 1'b1;
    #1;
    chk("overlap_ready", W_C'(in_ready), W_C'(1));
    push_exp();
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();

    // Abort by reset in the second busy cycle.
    send(rnd_op(2), rnd_op(2), '0, 4'h9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_in_ready", W_C'(in_ready), '0);
    chk("abort_valid", W_C'(out_valid), W_C'(L < 2));
    void'(q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", W_C'(in_ready), W_C'(1));
    repeat (L + 3) @(negedge clk);
    #1;
    chk("abort_no_result", W_C'(out_valid), '0);
    @(negedge clk);

    // Random requests with input gaps and output back-pressure.
    rnd_ord = 1'b1;
    n       = 0;
    guard   = 0;
    while (n < NREQ && guard < 90000) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_a     = rnd_op($urandom_range(0, 7));
      in_b     = W_B'(rnd_op($urandom_range(0, 7)));
      in_c     = {rnd_op($urandom_range(0, 7)),
                  rnd_op($urandom_range(0, 7))};
      in_tag   = ID_W'($urandom);
      #1;
      if (in_valid && in_ready) begin
        push_exp();
        n++;
      end
      @(negedge clk);
      guard++;
    end
    if (n < NREQ) fail_now("random_timeout");
    in_valid  = 1'b0;
    rnd_ord   = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
